// File: rtl/vaddsws_arb.sv
// vaddsws_arb: round-robin arbiter in front of one shared signed-saturating
// 32-bit word adder. Grants one requester per cycle, registers the saturated
// sum, per-op saturation flag and requester ID into a single-entry output
// stage with valid/ready handshake, and keeps the sticky SAT status bit.
module vaddsws_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_vra,
  input  logic [NREQ*32-1:0]   req_vrb,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_vrt,
  output logic                 rsp_sat,
  input  logic                 sat_clr,
  output logic                 sat_sticky
);

  localparam int unsigned N = NREQ;

  // Grant pointer and result-stage registers.
  logic [IDW-1:0] last_q, last_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_vrt_q, rsp_vrt_d;
  logic           rsp_sat_q, rsp_sat_d;
  logic           sticky_q, sticky_d;

  // Arbitration results.
  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            can_accept;
  logic            accept;

  // Datapath.
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [32:0] sum;
  logic [31:0] sat_vrt;
  logic        sat_flag;

  // Rotating-priority search: first valid requester starting at last+1, with wrap.
  always_comb begin
    int unsigned cand;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(last_q) + 32'd1 + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!gnt_any && req_valid[IDW'(cand)]) begin
        gnt_any              = 1'b1;
        gnt_idx              = IDW'(cand);
        gnt_oh[IDW'(cand)]   = 1'b1;
      end
    end
  end

  // Accept handshake: the stage can load when empty or being drained this cycle.
  always_comb begin
    can_accept = !rsp_valid_q || rsp_ready;
    req_ready  = gnt_oh & {NREQ{can_accept}};
    accept     = gnt_any && can_accept;
  end

  // Operand select for the granted requester and 33-bit signed add with saturation.
  always_comb begin
    op_a     = req_vra[{gnt_idx, 5'b00000} +: 32];
    op_b     = req_vrb[{gnt_idx, 5'b00000} +: 32];
    sum      = {op_a[31], op_a} + {op_b[31], op_b};
    sat_vrt  = sum[31:0];
    sat_flag = 1'b0;
    unique case (sum[32:31])
      2'b01: begin
        sat_vrt  = 32'h7FFF_FFFF;
        sat_flag = 1'b1;
      end
      2'b10: begin
        sat_vrt  = 32'h8000_0000;
        sat_flag = 1'b1;
      end
      default: begin
        sat_vrt  = sum[31:0];
        sat_flag = 1'b0;
      end
    endcase
  end

  // Next-state for pointer, result stage and sticky SAT (set beats clear).
  always_comb begin
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_vrt_d   = rsp_vrt_q;
    rsp_sat_d   = rsp_sat_q;
    sticky_d    = sticky_q;

    if (accept) begin
      last_d      = gnt_idx;
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_vrt_d   = sat_vrt;
      rsp_sat_d   = sat_flag;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (accept && sat_flag) begin
      sticky_d = 1'b1;
    end else if (sat_clr) begin
      sticky_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_vrt_q   <= '0;
      rsp_sat_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_vrt_q   <= rsp_vrt_d;
      rsp_sat_q   <= rsp_sat_d;
      sticky_q    <= sticky_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_vrt    = rsp_vrt_q;
  assign rsp_sat    = rsp_sat_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_vaddsws_arb.sv
// Testbench for vaddsws_arb: reference model of the arbiter and saturating
// adder, scoreboard queue of expected results, and per-feature scenario tasks.
module tb_vaddsws_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_vra;
  logic [NREQ*32-1:0]  req_vrb;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_vrt;
  logic                rsp_sat;
  logic                sat_clr;
  logic                sat_sticky;

  always #5 clk = ~clk;

  vaddsws_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_vra    (req_vra),
    .req_vrb    (req_vrb),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_vrt    (rsp_vrt),
    .rsp_sat    (rsp_sat),
    .sat_clr    (sat_clr),
    .sat_sticky (sat_sticky)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    vrt;
    logic           sat;
  } res_t;

  res_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model state.
  logic m_valid;
  int   m_last;
  logic m_sticky;

  function automatic res_t model_add(int id, logic [31:0] a, logic [31:0] b);
    res_t r;
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    r.id = IDW'(id);
    if (s > 64'sd2147483647) begin
      r.vrt = 32'h7FFF_FFFF;
      r.sat = 1'b1;
    end else if (s < -64'sd2147483648) begin
      r.vrt = 32'h8000_0000;
      r.sat = 1'b1;
    end else begin
      r.vrt = s[31:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

  task automatic reset_model();
    exp_q.delete();
    m_valid  = 1'b0;
    m_last   = NREQ - 1;
    m_sticky = 1'b0;
  endtask

  task automatic set_op(int i, logic [31:0] a, logic [31:0] b);
    req_vra[32*i +: 32] = a;
    req_vrb[32*i +: 32] = b;
  endtask

  // One clock: predict grant, push on accept, pop on drain, compare result stage.
  task automatic step();
    int              g;
    int              idx;
    logic [NREQ-1:0] exp_ready;
    logic            acc;
    logic            drained;
    res_t            r;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_last + 1 + k) % NREQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    exp_ready = '0;
    if (g >= 0 && (!m_valid || rsp_ready)) exp_ready[g] = 1'b1;
    total++;
    if (req_ready !== exp_ready) $display("FAIL req_ready: got %b expected %b", req_ready, exp_ready);
    else passed++;
    acc     = (exp_ready != '0);
    drained = m_valid && rsp_ready;
    r       = '0;
    if (acc) begin
      r = model_add(g, req_vra[32*g +: 32], req_vrb[32*g +: 32]);
      exp_q.push_back(r);
    end
    @(posedge clk);
    if (drained) void'(exp_q.pop_front());
    if (acc) begin
      m_valid = 1'b1;
      m_last  = g;
    end else if (drained) begin
      m_valid = 1'b0;
    end
    if (acc && r.sat) m_sticky = 1'b1;
    else if (sat_clr) m_sticky = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== m_valid) $display("FAIL rsp_valid: got %b expected %b", rsp_valid, m_valid);
    else passed++;
    total++;
    if (sat_sticky !== m_sticky) $display("FAIL sat_sticky: got %b expected %b", sat_sticky, m_sticky);
    else passed++;
    if (m_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard: got empty queue expected one entry");
      end else if ({rsp_id, rsp_vrt, rsp_sat} !== {exp_q[0].id, exp_q[0].vrt, exp_q[0].sat}) begin
        $display("FAIL rsp_entry: got id=%0d vrt=%h sat=%b expected id=%0d vrt=%h sat=%b",
                 rsp_id, rsp_vrt, rsp_sat, exp_q[0].id, exp_q[0].vrt, exp_q[0].sat);
      end else begin
        passed++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_vra   = '0;
    req_vrb   = '0;
    rsp_ready = 1'b0;
    sat_clr   = 1'b0;
    reset_model();
    #12;
    total++;
    if ({rsp_valid, rsp_id, rsp_vrt, rsp_sat, sat_sticky, req_ready} !== '0)
      $display("FAIL reset_outputs: got v=%b id=%0d vrt=%h sat=%b st=%b rdy=%b expected all zero",
               rsp_valid, rsp_id, rsp_vrt, rsp_sat, sat_sticky, req_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_add();
    rsp_ready = 1'b1;
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b0001;
    step();
    total++;
    if ({rsp_vrt, rsp_sat, rsp_id, sat_sticky} !== {32'hFFFF_FFFE, 1'b0, 2'd0, 1'b0})
      $display("FAIL add_neg_one: got vrt=%h sat=%b id=%0d st=%b expected vrt=fffffffe sat=0 id=0 st=0",
               rsp_vrt, rsp_sat, rsp_id, sat_sticky);
    else passed++;

    set_op(1, 32'h1111_1111, 32'h2222_2222);
    req_valid = 4'b0010;
    step();
    total++;
    if ({rsp_vrt, rsp_sat, rsp_id} !== {32'h3333_3333, 1'b0, 2'd1})
      $display("FAIL add_plain: got vrt=%h sat=%b id=%0d expected vrt=33333333 sat=0 id=1",
               rsp_vrt, rsp_sat, rsp_id);
    else passed++;
  endtask

  task automatic test_saturation();
    set_op(2, 32'h7FFF_FFFF, 32'h0000_0001);
    req_valid = 4'b0100;
    step();
    total++;
    if ({rsp_vrt, rsp_sat, rsp_id, sat_sticky} !== {32'h7FFF_FFFF, 1'b1, 2'd2, 1'b1})
      $display("FAIL sat_pos: got vrt=%h sat=%b id=%0d st=%b expected vrt=7fffffff sat=1 id=2 st=1",
               rsp_vrt, rsp_sat, rsp_id, sat_sticky);
    else passed++;

    set_op(3, 32'h8000_0000, 32'hFFFF_FFFF);
    req_valid = 4'b1000;
    step();
    total++;
    if ({rsp_vrt, rsp_sat, rsp_id} !== {32'h8000_0000, 1'b1, 2'd3})
      $display("FAIL sat_neg: got vrt=%h sat=%b id=%0d expected vrt=80000000 sat=1 id=3",
               rsp_vrt, rsp_sat, rsp_id);
    else passed++;

    req_valid = '0;
    step();
    total++;
    if (rsp_valid !== 1'b0) $display("FAIL drain_idle: got %b expected 0", rsp_valid);
    else passed++;
  endtask

  task automatic test_round_robin();
    int ids[6] = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i * 100 + 7), 32'(-(i * 3)));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(ids[n]))
        $display("FAIL rr_seq%0d: got v=%b id=%0d expected v=1 id=%0d", n, rsp_valid, rsp_id, ids[n]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      total++;
      if (req_ready !== '0 || rsp_id !== 2'd1 || rsp_valid !== 1'b1)
        $display("FAIL stall%0d: got rdy=%b id=%0d v=%b expected rdy=0000 id=1 v=1",
                 n, req_ready, rsp_id, rsp_valid);
      else passed++;
    end
    rsp_ready = 1'b1;
    step();
    total++;
    if (rsp_id !== 2'd2) $display("FAIL stall_release: got id=%0d expected 2", rsp_id);
    else passed++;
  endtask

  task automatic test_sticky();
    req_valid = '0;
    step();
    set_op(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    req_valid = 4'b1000;
    sat_clr   = 1'b1;
    step();
    total++;
    if (sat_sticky !== 1'b1 || rsp_sat !== 1'b1)
      $display("FAIL sticky_set_wins: got st=%b sat=%b expected st=1 sat=1", sat_sticky, rsp_sat);
    else passed++;
    req_valid = '0;
    step();
    total++;
    if (sat_sticky !== 1'b0) $display("FAIL sticky_clear: got %b expected 0", sat_sticky);
    else passed++;
    sat_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_op(0, 32'h8000_0000, 32'h8000_0000);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_vrt, rsp_sat, sat_sticky} !== '0)
      $display("FAIL reset_mid: got v=%b id=%0d vrt=%h sat=%b st=%b expected all zero",
               rsp_valid, rsp_id, rsp_vrt, rsp_sat, sat_sticky);
    else passed++;
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (rsp_id !== 2'd0 || rsp_valid !== 1'b1 || sat_sticky !== 1'b1)
      $display("FAIL restart_req0: got id=%0d v=%b st=%b expected id=0 v=1 st=1",
               rsp_id, rsp_valid, sat_sticky);
    else passed++;
    req_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_saturation();
    test_round_robin();
    test_backpressure();
    test_sticky();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vaddsws_arb.md
# vaddsws_arb

Round-robin arbiter and result sequencer that shares one signed-saturating 32-bit word adder (vaddsws datapath) among NREQ requesters in the vsfx unit. It grants one request per cycle and registers the sum and per-operation saturation flag into a single-entry output stage with valid/ready backpressure. It also maintains the sticky SAT status bit that feeds VSCR[SAT].

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(NREQ), width of the requester-ID field
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- req_valid  in  NREQ  per-requester operation request
- req_vra  in  NREQ*32  operand A; requester i uses bits [32*i+31:32*i]
- req_vrb  in  NREQ*32  operand B, same packing
- req_ready  out  NREQ  one-hot accept; at most one bit set per cycle
- rsp_valid  out  1  result stage holds a result
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that produced rsp_vrt
- rsp_vrt  out  32  saturated sum
- rsp_sat  out  1  this result saturated
- sat_clr  in  1  synchronous clear of sat_sticky
- sat_sticky  out  1  OR of rsp_sat over all results captured since reset or last clear

## Operation
- Arithmetic: 33-bit signed sum of the sign-extended operands. If sum > 0x7FFFFFFF, vrt = 0x7FFFFFFF and sat = 1. If sum < -0x80000000, vrt = 0x80000000 and sat = 1. Otherwise vrt = sum[31:0] and sat = 0.
- can_accept = !rsp_valid | rsp_ready.
- Grant: the first i with req_valid[i] = 1, searching from (last+1) mod NREQ upward with wrap.
  - req_ready[i] = grant[i] & can_accept; this path is combinational from req_valid, rsp_valid and rsp_ready.
  - A request is accepted when req_valid[i] & req_ready[i].
- Pointer `last`:
  - Updates to the granted index only on accept.
  - Holds when nothing is accepted, so a stalled grant stays with the same requester.
  - Reset value is NREQ-1, so requester 0 has priority first.
- On accept, the result stage loads vrt, sat and the requester ID, and rsp_valid is set.
- If rsp_valid & rsp_ready and there is no accept, rsp_valid clears.
- A simultaneous drain and accept replaces the entry; rsp_valid stays 1, giving full throughput.
- While rsp_valid & !rsp_ready, rsp_vrt, rsp_id and rsp_sat hold stable.
- sat_sticky:
  - Set on any accept whose sat = 1.
  - Cleared by sat_clr.
  - If set and clear occur in the same cycle, set wins.
- Requesters must hold req_valid and operands stable until accepted. The block does not check this.

## Timing
- Reset values (asynchronous, on rst_n low): rsp_valid 0, rsp_vrt 0, rsp_id 0, rsp_sat 0, sat_sticky 0, last NREQ-1. req_ready is 0 whenever req_valid is 0.
- Latency: a request accepted in cycle N appears with rsp_valid = 1 in cycle N+1.
- Throughput: one result per cycle while rsp_ready is held 1.
- Back-pressure: with rsp_valid = 1 and rsp_ready = 0, all req_ready are 0 and there is no grant-pointer movement.
- Reset mid-operation: any pending result is dropped and sat_sticky is lost. Arbitration restarts at requester 0.
- Fairness: with all NREQ requesters continuously valid and no stall, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 accepts.

## Test plan
- Reset, then req0 with vra = 0xFFFFFFFF, vrb = 0xFFFFFFFF and rsp_ready = 1 -> next cycle rsp_vrt = 0xFFFFFFFE, rsp_sat = 0, rsp_id = 0, sat_sticky = 0.
- req1 with 0x11111111 + 0x22222222 -> rsp_vrt = 0x33333333, rsp_sat = 0, rsp_id = 1.
- req2 with 0x7FFFFFFF + 0x00000001 -> rsp_vrt = 0x7FFFFFFF, rsp_sat = 1, sat_sticky = 1. Then req3 with 0x80000000 + 0xFFFFFFFF -> rsp_vrt = 0x80000000, rsp_sat = 1.
- All four requesters valid continuously with rsp_ready = 1 -> rsp_id sequence 0,1,2,3,0,1 with rsp_valid high every cycle.
- rsp_ready = 0 for 3 cycles with a result pending and requests waiting -> req_ready = 0 and the rsp_* outputs hold. On release, the waiting grant goes to the same requester as before the stall.
- sat_sticky = 1, then sat_clr pulsed in the same cycle as accepting a saturating op -> sat_sticky stays 1. sat_clr alone in the next cycle -> sat_sticky = 0. rst_n asserted mid-stream -> all outputs return to their reset values immediately.
